// File: rtl/life_pkg.sv
// Shared definitions for the life_sequencer block: default grid geometry,
// command opcodes, controller state encoding and a small index-width helper.
// No ports; imported by the interface, the scan shifter and the top.
package life_pkg;

  localparam int DEF_WIDTH    = 17;
  localparam int DEF_HEIGHT   = 17;
  localparam int DEF_CELL_NUM = DEF_WIDTH * DEF_HEIGHT;
  localparam int DEF_GEN_W    = 16;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_RUN  = 2'd1,
    OP_STEP = 2'd2,
    OP_RSVD = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_APPLY  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SCAN   = 3'd4
  } state_e;

  // Bits needed to index n cells (at least 1).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/life_sequencer_if.sv
// Bundle of every non-clock/reset signal of life_sequencer.
//   command : cmd_valid/cmd_ready, cmd_op, cmd_count, stop
//   load    : load_valid/load_ready, load_bit
//   array   : grid_init, grid_load, grid_step, grid_states
//   scan    : out_valid/out_ready, out_bit, out_last
//   status  : busy, gen_count, still
// slave  = sequencer view, master = controller/environment view.
// CELL_NUM and GEN_W must match the parameters of the attached sequencer.
interface life_sequencer_if #(
  parameter int CELL_NUM = life_pkg::DEF_CELL_NUM,
  parameter int GEN_W    = life_pkg::DEF_GEN_W
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [GEN_W-1:0]    cmd_count;
  logic                stop;

  logic                load_valid;
  logic                load_ready;
  logic                load_bit;

  logic [CELL_NUM-1:0] grid_init;
  logic                grid_load;
  logic                grid_step;
  logic [CELL_NUM-1:0] grid_states;

  logic                out_valid;
  logic                out_ready;
  logic                out_bit;
  logic                out_last;

  logic                busy;
  logic [GEN_W-1:0]    gen_count;
  logic                still;

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, stop,
    input  load_valid, load_bit,
    input  grid_states,
    input  out_ready,
    output cmd_ready, load_ready,
    output grid_init, grid_load, grid_step,
    output out_valid, out_bit, out_last,
    output busy, gen_count, still
  );

  modport master (
    output cmd_valid, cmd_op, cmd_count, stop,
    output load_valid, load_bit,
    output grid_states,
    output out_ready,
    input  cmd_ready, load_ready,
    input  grid_init, grid_load, grid_step,
    input  out_valid, out_bit, out_last,
    input  busy, gen_count, still
  );

endinterface

// File: rtl/life_scan_shifter.sv
// Frame scan-out engine: captures a snapshot of the cell array and presents
// it one bit per accepted transfer, index 0 first.
// Ports:
//   clock, reset    - clock, synchronous active-high reset
//   capture_i       - load snapshot from data_i and start a frame
//   data_i          - live cell states
//   out_ready_i     - downstream ready
//   out_valid_o/out_bit_o/out_last_o - serial frame handshake
//   frame_done_o    - last bit of the frame accepted this cycle
//   same_o          - data_i equals the retained snapshot (still-life compare)
// Macro LIFE_STILL_DETECT_EN enables the snapshot compare; otherwise same_o is 0.
module life_scan_shifter
  import life_pkg::*;
#(
  parameter int CELL_NUM = DEF_CELL_NUM
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                capture_i,
  input  logic [CELL_NUM-1:0] data_i,
  input  logic                out_ready_i,
  output logic                out_valid_o,
  output logic                out_bit_o,
  output logic                out_last_o,
  output logic                frame_done_o,
  output logic                same_o
);

  localparam int IDX_W = idx_width(CELL_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_NUM - 1);

  logic [CELL_NUM-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                active_q, active_d;
  logic                xfer;
  logic                at_last;

  assign xfer         = active_q && out_ready_i;
  assign at_last      = (idx_q == LAST_IDX);
  assign out_valid_o  = active_q;
  assign out_bit_o    = snap_q[idx_q];
  assign out_last_o   = active_q && at_last;
  assign frame_done_o = xfer && at_last;

  // The snapshot register still holds the previous frame when a new capture
  // is about to happen, so it doubles as the "previous generation" store.
`ifdef LIFE_STILL_DETECT_EN
  assign same_o = (data_i == snap_q);
`else
  assign same_o = 1'b0;
`endif

  always_comb begin
    snap_d   = snap_q;
    idx_d    = idx_q;
    active_d = active_q;
    if (capture_i) begin
      snap_d   = data_i;
      idx_d    = '0;
      active_d = 1'b1;
    end else if (xfer) begin
      if (at_last) begin
        idx_d    = '0;
        active_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      snap_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Game-of-life sequencer: loads an initial pattern serially, drives the
// external cell array (grid_load / grid_step), waits for it to settle and
// scans each generation out serially.
// Ports:
//   clock, reset - clock, synchronous active-high reset
//   bus          - life_sequencer_if.slave (command, load, array, scan, status)
// Macro LIFE_STILL_DETECT_EN (in life_scan_shifter) enables still-life stop.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// LOAD   | accepting CELL_NUM pattern bits into grid_init
// APPLY  | one cycle: grid_load after LOAD, else grid_step (or exit if none left)
// SETTLE | two cycles for the cell array outputs to become valid
// SCAN   | snapshot taken, frame shifted out
module life_sequencer
  import life_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int GEN_W  = DEF_GEN_W
) (
  input  logic            clock,
  input  logic            reset,
  life_sequencer_if.slave bus
);

  localparam int CELL_NUM = WIDTH * HEIGHT;
  localparam int IDX_W    = idx_width(CELL_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_NUM - 1);

  state_e              state_q, state_d;
  logic [CELL_NUM-1:0] grid_init_q, grid_init_d;
  logic [IDX_W-1:0]    load_idx_q, load_idx_d;
  logic [GEN_W-1:0]    gen_q, gen_d;
  logic [GEN_W-1:0]    rem_q, rem_d;
  logic                settle_q, settle_d;
  logic                is_load_q, is_load_d;
  logic                still_q, still_d;
  logic                snap_capture;
  logic                frame_done;
  logic                same;

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.load_ready = (state_q == ST_LOAD);
  assign bus.grid_init  = grid_init_q;
  assign bus.grid_load  = (state_q == ST_APPLY) && is_load_q;
  assign bus.grid_step  = (state_q == ST_APPLY) && !is_load_q && (rem_q != '0);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.gen_count  = gen_q;
  assign bus.still      = still_q;

  life_scan_shifter #(
    .CELL_NUM (CELL_NUM)
  ) u_scan (
    .clock        (clock),
    .reset        (reset),
    .capture_i    (snap_capture),
    .data_i       (bus.grid_states),
    .out_ready_i  (bus.out_ready),
    .out_valid_o  (bus.out_valid),
    .out_bit_o    (bus.out_bit),
    .out_last_o   (bus.out_last),
    .frame_done_o (frame_done),
    .same_o       (same)
  );

  always_comb begin
    state_d      = state_q;
    grid_init_d  = grid_init_q;
    load_idx_d   = load_idx_q;
    gen_d        = gen_q;
    rem_d        = rem_q;
    settle_d     = settle_q;
    is_load_d    = is_load_q;
    still_d      = still_q;
    snap_capture = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          still_d = 1'b0;
          case (cmd_op_e'(bus.cmd_op))
            OP_LOAD: begin
              load_idx_d = '0;
              state_d    = ST_LOAD;
            end
            OP_RUN: begin
              rem_d     = bus.cmd_count;
              is_load_d = 1'b0;
              state_d   = ST_APPLY;
            end
            OP_STEP: begin
              rem_d     = GEN_W'(1);
              is_load_d = 1'b0;
              state_d   = ST_APPLY;
            end
            default: ;
          endcase
        end
      end

      ST_LOAD: begin
        if (bus.load_valid) begin
          grid_init_d[load_idx_q] = bus.load_bit;
          if (load_idx_q == LAST_IDX) begin
            gen_d     = '0;
            rem_d     = '0;
            is_load_d = 1'b1;
            state_d   = ST_APPLY;
          end else begin
            load_idx_d = load_idx_q + IDX_W'(1);
          end
        end
      end

      ST_APPLY: begin
        // RUN 0 lands here with nothing left and goes straight back to IDLE.
        if (is_load_q) begin
          settle_d = 1'b1;
          state_d  = ST_SETTLE;
        end else if (rem_q != '0) begin
          gen_d    = gen_q + GEN_W'(1);
          rem_d    = rem_q - GEN_W'(1);
          settle_d = 1'b1;
          state_d  = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (settle_q == 1'b0) begin
          snap_capture = 1'b1;
          // Only a stepped generation can be a still life; the load frame
          // is never compared against whatever was scanned before it.
          if (!is_load_q && same) still_d = 1'b1;
          state_d = ST_SCAN;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      ST_SCAN: begin
        if (frame_done) begin
          if ((rem_q != '0) && !bus.stop && !still_q) begin
            is_load_d = 1'b0;
            state_d   = ST_APPLY;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grid_init_q <= '0;
      load_idx_q  <= '0;
      gen_q       <= '0;
      rem_q       <= '0;
      settle_q    <= 1'b0;
      is_load_q   <= 1'b0;
      still_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grid_init_q <= grid_init_d;
      load_idx_q  <= load_idx_d;
      gen_q       <= gen_d;
      rem_q       <= rem_d;
      settle_q    <= settle_d;
      is_load_q   <= is_load_d;
      still_q     <= still_d;
    end
  end

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer on a 5x5 grid with a behavioural
// two-cycle-latency cell array; expected frames go into a scoreboard queue
// and a separate monitor compares every scanned frame against it.
module tb_life_sequencer;
  import life_pkg::*;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int CN = W * H;
  localparam int GW = 16;

  localparam logic [CN-1:0] BLINK_V = 25'h0021080; // 7,12,17
  localparam logic [CN-1:0] BLINK_H = 25'h0003800; // 11,12,13
  localparam logic [CN-1:0] BLOCK   = 25'h00018C0; // 6,7,11,12

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  life_sequencer_if #(.CELL_NUM(CN), .GEN_W(GW)) bus();

  life_sequencer #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_steps = 0;
  int n_loads = 0;
  int frames_seen = 0;
  int mon_idx = 0;
  logic [CN-1:0] mon_frame = '0;
  logic [CN-1:0] exp_q[$];
  bit ready_toggle = 0;
  bit hold = 0;
  logic hold_bit, hold_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CN-1:0] life_next(input logic [CN-1:0] g);
    logic [CN-1:0] nx;
    nx = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < H &&
                c + dc >= 0 && c + dc < W && g[(r + dr) * W + c + dc])
              cnt++;
        nx[r * W + c] = g[r * W + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return nx;
  endfunction

  // Cell array model: states valid two cycles after a load/step pulse.
  logic [CN-1:0] stage_q, cells_q;
  always @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      cells_q <= '0;
    end else begin
      if (bus.grid_load)      stage_q <= bus.grid_init;
      else if (bus.grid_step) stage_q <= life_next(cells_q);
      cells_q <= stage_q;
    end
  end
  assign bus.grid_states = cells_q;

  always @(negedge clk) begin
    if (bus.grid_step) n_steps++;
    if (bus.grid_load) n_loads++;
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_toggle) bus.out_ready = ~bus.out_ready;
      else bus.out_ready = 1'b1;
    end
  end

  // Monitor: held-output stability plus frame-by-frame scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      mon_idx   = 0;
      mon_frame = '0;
      hold      = 0;
      exp_q.delete();
    end else begin
      if (hold)
        check("hold_stable", {bus.out_valid, bus.out_bit, bus.out_last}, {1'b1, hold_bit, hold_last});
      hold      = bus.out_valid && !bus.out_ready;
      hold_bit  = bus.out_bit;
      hold_last = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        mon_frame[mon_idx] = bus.out_bit;
        if (bus.out_last || mon_idx == CN - 1) begin
          check("last_flag", bus.out_last, 1);
          check("last_index", mon_idx, CN - 1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_frame: got 0x%0h, expected no frame", mon_frame);
          end else begin
            check("frame", mon_frame, exp_q.pop_front());
          end
          frames_seen++;
          mon_idx   = 0;
          mon_frame = '0;
        end else begin
          mon_idx++;
        end
      end
    end
  end

  task automatic do_cmd(input logic [1:0] op, input logic [GW-1:0] cnt);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_count = cnt;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_load(input logic [CN-1:0] pat);
    int n;
    do_cmd(OP_LOAD, '0);
    for (int k = 0; k < CN; k++) begin
      bus.load_valid = 1'b1;
      bus.load_bit   = pat[k];
      @(negedge clk);
      n = 0;
      while (!bus.load_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!bus.load_ready) begin
        n_cmp++;
        n_fail++;
        $display("FAIL load_ready_timeout: got 0, expected 1 at bit %0d", k);
      end
      @(posedge clk); #1;
    end
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.busy, 0);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_steps, b_loads, b_frames, n;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'd0;
    bus.cmd_count  = '0;
    bus.stop       = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_bit   = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_pulses", {bus.busy, bus.grid_load, bus.grid_step, bus.out_valid, bus.out_last, bus.load_ready}, 0);
    check("rst_gen", bus.gen_count, 0);
    check("rst_still", bus.still, 0);
    check("rst_grid_init", bus.grid_init, 0);

    // LOAD blinker: one grid_load, one generation-0 frame.
    b_steps = n_steps; b_loads = n_loads; b_frames = frames_seen;
    exp_q.push_back(BLINK_V);
    do_load(BLINK_V);
    wait_idle(300, "load_idle");
    check("load_pulses", n_loads - b_loads, 1);
    check("load_steps", n_steps - b_steps, 0);
    check("load_frames", frames_seen - b_frames, 1);
    check("load_gen", bus.gen_count, 0);
    check("load_grid_init", bus.grid_init, BLINK_V);

    // RUN 2: horizontal then vertical.
    b_steps = n_steps; b_frames = frames_seen;
    exp_q.push_back(BLINK_H);
    exp_q.push_back(BLINK_V);
    do_cmd(OP_RUN, 16'd2);
    wait_idle(500, "run2_idle");
    check("run2_steps", n_steps - b_steps, 2);
    check("run2_frames", frames_seen - b_frames, 2);
    check("run2_gen", bus.gen_count, 2);

    // RUN 0: busy for exactly one cycle, nothing else.
    b_steps = n_steps; b_frames = frames_seen;
    do_cmd(OP_RUN, 16'd0);
    @(negedge clk);
    check("run0_ready_low", bus.cmd_ready, 0);
    @(negedge clk);
    check("run0_ready_back", bus.cmd_ready, 1);
    repeat (5) @(negedge clk);
    check("run0_steps", n_steps - b_steps, 0);
    check("run0_frames", frames_seen - b_frames, 0);

    // STEP: one generation.
    b_steps = n_steps;
    exp_q.push_back(BLINK_H);
    do_cmd(OP_STEP, 16'd0);
    wait_idle(300, "step_idle");
    check("step_steps", n_steps - b_steps, 1);
    check("step_gen", bus.gen_count, 3);

    // Reserved opcode: accepted, no action.
    b_frames = frames_seen;
    do_cmd(OP_RSVD, 16'd7);
    @(negedge clk);
    check("rsvd_busy", bus.busy, 0);
    check("rsvd_gen", bus.gen_count, 3);

    // RUN 5 with stop raised during frame 2 and ready toggling.
    exp_q.push_back(BLINK_V);
    do_load(BLINK_V);
    wait_idle(300, "reload_idle");
    check("reload_gen", bus.gen_count, 0);
    b_steps = n_steps; b_frames = frames_seen;
    ready_toggle = 1;
    exp_q.push_back(BLINK_H);
    exp_q.push_back(BLINK_V);
    do_cmd(OP_RUN, 16'd5);
    n = 0;
    while (frames_seen < b_frames + 1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("stop_frame1_seen", frames_seen - b_frames, 1);
    repeat (10) @(posedge clk);
    #1 bus.stop = 1'b1;
    wait_idle(1000, "stop_idle");
    bus.stop = 1'b0;
    ready_toggle = 0;
    check("stop_steps", n_steps - b_steps, 2);
    check("stop_frames", frames_seen - b_frames, 2);
    check("stop_gen", bus.gen_count, 2);

    // Block (still life), RUN 10.
    exp_q.push_back(BLOCK);
    do_load(BLOCK);
    wait_idle(300, "block_load_idle");
    b_steps = n_steps; b_frames = frames_seen;
`ifdef LIFE_STILL_DETECT_EN
    exp_q.push_back(BLOCK);
    do_cmd(OP_RUN, 16'd10);
    wait_idle(1000, "block_run_idle");
    check("block_still", bus.still, 1);
    check("block_gen", bus.gen_count, 1);
    check("block_frames", frames_seen - b_frames, 1);
    do_cmd(OP_RSVD, 16'd0);
    @(negedge clk);
    check("still_cleared", bus.still, 0);
`else
    for (int i = 0; i < 10; i++) exp_q.push_back(BLOCK);
    do_cmd(OP_RUN, 16'd10);
    wait_idle(3000, "block_run_idle");
    check("block_still", bus.still, 0);
    check("block_gen", bus.gen_count, 10);
    check("block_frames", frames_seen - b_frames, 10);
`endif

    // Reset while scan bit 8 is presented.
    exp_q.push_back(BLOCK);
    do_cmd(OP_RUN, 16'd3);
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!(bus.out_valid && mon_idx == 8) && n < 300);
    check("scan_bit8_reached", {bus.out_valid, 8'(mon_idx)}, {1'b1, 8'd8});
    rst = 1'b1;
    b_steps = n_steps; b_loads = n_loads; b_frames = frames_seen;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_gen", bus.gen_count, 0);
    check("midrst_grid_init", bus.grid_init, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_steps", n_steps - b_steps, 0);
    check("midrst_loads", n_loads - b_loads, 0);
    check("midrst_frames", frames_seen - b_frames, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/life_sequencer.md
LIFE_SEQUENCER -- requirements
Module: life_sequencer

Interface
REQ-001 Parameter WIDTH, 17, grid columns.
REQ-002 Parameter HEIGHT, 17, grid rows; CELL_NUM = WIDTH*HEIGHT, cell index = row*WIDTH+col.
REQ-003 Parameter GEN_W, 16, width of generation count and counter.
REQ-004 clock  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake; transfer when both high.
REQ-007 cmd_op  in  2  0=LOAD, 1=RUN, 2=STEP, 3=reserved (accepted, no action).
REQ-008 cmd_count  in  GEN_W  generations for RUN.
REQ-009 stop  in  1  level request to end RUN at next generation boundary.
REQ-010 load_valid/load_ready/load_bit  in/out/in  1/1/1  serial initial pattern, index 0 first.
REQ-011 grid_init  out  CELL_NUM  pattern driven to cell array init inputs.
REQ-012 grid_load  out  1  one-cycle pulse; cell array captures grid_init.
REQ-013 grid_step  out  1  one-cycle pulse; cell array advances one generation.
REQ-014 grid_states  in  CELL_NUM  current cell states; valid 2 cycles after grid_load/grid_step.
REQ-015 out_valid/out_ready/out_bit/out_last  out/in/out/out  1 each  serial scan-out, index 0 first, out_last on index CELL_NUM-1.
REQ-016 busy  out  1  high whenever state != IDLE.
REQ-017 gen_count  out  GEN_W  generations stepped since last LOAD.
REQ-018 still  out  1  still-life flag (see Configuration).

Function
REQ-019 States SHALL be IDLE, LOAD, APPLY, SETTLE, SCAN; cmd_ready=1 only in IDLE.
REQ-020 LOAD: load_ready=1; each accepted bit written to grid_init[k], k=0..CELL_NUM-1; after bit CELL_NUM-1 -> APPLY with grid_load pulsed; gen_count cleared to 0.
REQ-021 RUN with cmd_count=0 SHALL return to IDLE next cycle with no grid_step; STEP equals RUN with count 1.
REQ-022 RUN N>0: APPLY pulses grid_step one cycle, gen_count+1 (wrap mod 2^GEN_W), remaining-1; SETTLE holds exactly 2 cycles; then SCAN.
REQ-023 SCAN entry SHALL snapshot grid_states; out_bit driven from snapshot only, so grid changes never corrupt a frame.
REQ-024 out_valid held with out_bit/out_last stable until out_ready; CELL_NUM transfers per frame, no gaps forced by the block.
REQ-025 After last transfer: remaining>0 and stop low -> APPLY; else -> IDLE.
REQ-026 stop SHALL be sampled only at frame end; stop during LOAD or SETTLE has no effect until that point.
REQ-027 After LOAD, exactly one frame (generation 0) SHALL be scanned before IDLE.
REQ-028 Commands presented while busy SHALL wait (cmd_ready low), never dropped.

Reset
REQ-029 reset SHALL force IDLE, grid_init=0, gen_count=0, remaining=0, snapshot=0, still=0.
REQ-030 All pulse and valid outputs (grid_load, grid_step, out_valid, out_last, load_ready) SHALL be 0 in the cycle after reset; cmd_ready=1.
REQ-031 reset mid-frame or mid-load SHALL abandon the operation with no further grid_step or grid_load.

Configuration
REQ-032 Macro LIFE_STILL_DETECT_EN defined: previous snapshot retained; if new snapshot equals previous at SCAN entry, still=1 and RUN ends to IDLE after that frame regardless of remaining; still cleared on next accepted command.
REQ-033 Macro undefined: no previous-snapshot register, still tied 0, RUN ends only by count or stop.

Structure
REQ-034 Package life_pkg SHALL hold default WIDTH/HEIGHT, CELL_NUM, cmd_op encodings, state encoding.
REQ-035 Sub-module life_scan_shifter SHALL hold snapshot, bit index and out_* handshake.

Verification
REQ-036 5x5 grid, LOAD blinker (indices 7,12,17) -> grid_load single pulse, frame of 25 bits with ones at 7,12,17, gen_count=0.
REQ-037 RUN 2 on blinker -> 2 grid_step pulses, frames ones at 11,12,13 then 7,12,17, gen_count=2.
REQ-038 RUN 0 -> cmd_ready low one cycle, no grid_step, no frame.
REQ-039 RUN 5, stop high during frame 2, out_ready toggling 50% -> frame 2 completes intact, IDLE, gen_count=2.
REQ-040 Block pattern, RUN 10 with LIFE_STILL_DETECT_EN -> still=1 after frame 1, gen_count=1; without macro -> 10 frames, still=0.
REQ-041 reset asserted at scan bit 8 -> out_valid low next cycle, busy=0, gen_count=0, no further grid_step.
